// File: rtl/enet_nios_timer_pkg.sv
// Shared register map, bit positions and reset constants for the cascade timer.
package enet_nios_timer_pkg;

    localparam int unsigned BUS_W   = 16;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned SLICE_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD_LO = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD_HI = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SNAP_LO   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_SNAP_HI   = 3'd5;

    localparam int unsigned STATUS_TO  = 0;
    localparam int unsigned STATUS_RUN = 1;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam logic [31:0] PERIOD_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/enet_nios_cascade_zero_detect.sv
// Combinational zero detect: per-nibble NOR terms ANDed along a cascade chain.
module enet_nios_cascade_zero_detect #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic [COUNT_W-1:0] count,
    output logic               zero_c
);
    import enet_nios_timer_pkg::*;

    localparam int unsigned NSLICE = (COUNT_W + SLICE_W - 1) / SLICE_W;
    localparam int unsigned PAD_W  = NSLICE * SLICE_W;

    logic [PAD_W-1:0] padded;
    logic [NSLICE:0]  cascade;

    // Zero-extend so a width that is not a multiple of the slice still works.
    assign padded     = PAD_W'(count);
    assign cascade[0] = 1'b1;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        assign cascade[i+1] = cascade[i] & ~(|padded[i*SLICE_W +: SLICE_W]);
    end

    assign zero_c = cascade[NSLICE];

endmodule

// File: rtl/enet_nios_cascade_timer.sv
// Avalon-style down-counting interval timer with sticky timeout and irq.
// Optional counter snapshot registers enabled by ENET_NIOS_TIMER_SNAPSHOT_EN.
module enet_nios_cascade_timer #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);
    import enet_nios_timer_pkg::*;

    logic [COUNT_W-1:0] counter, counter_nxt;
    logic [COUNT_W-1:0] period, period_nxt;
    logic               run, run_nxt;
    logic               to, to_nxt;
    logic               ito, ito_nxt;
    logic               cont, cont_nxt;
    logic [BUS_W-1:0]   rdata_nxt;
    logic               count_zero;
    logic               wr, rd, wr_period, zero_hit;
    logic [31:0]        period_wide;
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
    logic [COUNT_W-1:0] snap, snap_nxt;
    logic [31:0]        snap_wide;
`endif

    enet_nios_cascade_zero_detect #(.COUNT_W(COUNT_W)) u_zero (
        .count  (counter),
        .zero_c (count_zero)
    );

    // Next-state for counter, control/status flags and the read-data register.
    always_comb begin
        wr          = chipselect & ~write_n;
        rd          = chipselect & write_n;
        wr_period   = wr & ((address == ADDR_PERIOD_LO) | (address == ADDR_PERIOD_HI));
        zero_hit    = run & count_zero;
        period_wide = 32'(period);

        if (wr && address == ADDR_PERIOD_LO) period_wide[15:0]  = writedata;
        if (wr && address == ADDR_PERIOD_HI) period_wide[31:16] = writedata;
        period_nxt = COUNT_W'(period_wide);

        counter_nxt = counter;
        if (wr_period)     counter_nxt = period_nxt;
        else if (zero_hit) counter_nxt = period;
        else if (run)      counter_nxt = counter - COUNT_W'(1);

        ito_nxt  = ito;
        cont_nxt = cont;
        if (wr && address == ADDR_CONTROL) begin
            ito_nxt  = writedata[CTRL_ITO];
            cont_nxt = writedata[CTRL_CONT];
        end

        // Period writes and STOP dominate; a late START cannot revive a stopped count.
        run_nxt = run;
        if (wr_period)
            run_nxt = 1'b0;
        else if (wr && address == ADDR_CONTROL && writedata[CTRL_STOP])
            run_nxt = 1'b0;
        else if (zero_hit && !cont)
            run_nxt = 1'b0;
        else if (wr && address == ADDR_CONTROL && writedata[CTRL_START])
            run_nxt = 1'b1;

        to_nxt = to;
        if (zero_hit)                         to_nxt = 1'b1;
        else if (wr && address == ADDR_STATUS) to_nxt = 1'b0;

`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
        snap_nxt  = snap;
        if (wr && address == ADDR_SNAP_LO) snap_nxt = counter;
        snap_wide = 32'(snap);
`endif

        rdata_nxt = readdata;
        if (rd) begin
            rdata_nxt = '0;
            case (address)
                ADDR_STATUS: begin
                    rdata_nxt[STATUS_TO]  = to;
                    rdata_nxt[STATUS_RUN] = run;
                end
                ADDR_CONTROL: begin
                    rdata_nxt[CTRL_ITO]  = ito;
                    rdata_nxt[CTRL_CONT] = cont;
                end
                ADDR_PERIOD_LO: rdata_nxt = 16'(32'(period));
                ADDR_PERIOD_HI: rdata_nxt = 16'(32'(period) >> 16);
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
                ADDR_SNAP_LO:   rdata_nxt = snap_wide[15:0];
                ADDR_SNAP_HI:   rdata_nxt = snap_wide[31:16];
`endif
                default:        rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= COUNT_W'(PERIOD_RST);
            period   <= COUNT_W'(PERIOD_RST);
            run      <= 1'b0;
            to       <= 1'b0;
            ito      <= 1'b0;
            cont     <= 1'b0;
            readdata <= '0;
            irq      <= 1'b0;
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
            snap     <= '0;
`endif
        end else begin
            counter  <= counter_nxt;
            period   <= period_nxt;
            run      <= run_nxt;
            to       <= to_nxt;
            ito      <= ito_nxt;
            cont     <= cont_nxt;
            readdata <= rdata_nxt;
            irq      <= to_nxt & ito_nxt;
`ifdef ENET_NIOS_TIMER_SNAPSHOT_EN
            snap     <= snap_nxt;
`endif
        end
    end

endmodule

// File: doc/enet_nios_cascade_timer.md
ENET_NIOS_CASCADE_TIMER -- requirements
Module: enet_nios_cascade_timer

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, counter/period width (even, 8..32).
REQ-002 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: chipselect  input  1  slave select; address  input  3  register index; write_n  input  1  active-low write strobe.
REQ-005 SHALL have ports: writedata  input  16  write data; readdata  output  16  registered read data; irq  output  1  interrupt request.

Function
REQ-006 SHALL implement registers: 0 status (bit0 TO sticky timeout, bit1 RUN read-only); 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP); 2 period low 16 bits; 3 period high bits; 4 snap low; 5 snap high.
REQ-007 SHALL, when chipselect=1 and write_n=1, drive readdata on the next cycle with the addressed register; unused/unimplemented bits and addresses 6-7 read 0; readdata holds otherwise.
REQ-008 SHALL clear TO on any write to address 0; a timeout in the same cycle SHALL win (TO=1).
REQ-009 SHALL treat START/STOP as write-only pulses reading 0; STOP wins if both set; START while RUN=1 has no effect; STOP clears RUN next cycle and holds counter value.
REQ-010 SHALL, on write to address 2 or 3, update that period half, clear RUN, and load counter with the new full period next cycle.
REQ-011 SHALL, while RUN=1, decrement counter by 1 per clk.
REQ-012 SHALL detect counter==0 via the cascade zero-detect sub-module (REQ-020); on the cycle counter==0 with RUN=1: set TO, reload counter from period, clear RUN unless CONT=1.
REQ-013 SHALL, with period=0 and CONT=1, set TO every cycle (counter stays 0); with CONT=0 stop after one timeout.
REQ-014 SHALL drive irq = TO AND ITO, registered outputs only (no address-dependent combinational path).
REQ-015 SHALL ignore writes when chipselect=0; period writes SHALL take priority over START in the same cycle (impossible by address, documented).

Reset
REQ-016 SHALL on reset set: period=all ones, counter=all ones, RUN=0, TO=0, ITO=0, CONT=0, snap=0, readdata=0, irq=0.
REQ-017 SHALL, on reset mid-count, abandon the count with no timeout and no irq pulse.

Configuration
REQ-018 SHALL, with ENET_NIOS_TIMER_SNAPSHOT_EN defined, capture counter into snap on any write to address 4, readable at 4/5 (capture coincident with decrement captures pre-decrement value).
REQ-019 SHALL, without ENET_NIOS_TIMER_SNAPSHOT_EN, omit snap registers; addresses 4/5 read 0 and writes are ignored.

Structure
REQ-020 SHALL use one sub-module enet_nios_cascade_zero_detect: per-4-bit-slice NOR AND-chained through a cascade signal, combinational, COUNT_W input, 1-bit zero output.
REQ-021 SHALL place register address constants, control/status bit indices and reset period constant in shared package enet_nios_timer_pkg.

Verification
REQ-022 Reset, read address 2 and 3 -> 0xFFFF each; status reads 0; irq=0.
REQ-023 Write period=0x0000_0004, control=0x0005 (ITO|START) -> RUN=1, TO set 5 cycles after START effect, irq=1, RUN=0, counter=4.
REQ-024 Period=2, control=0x0007 (CONT) -> TO reasserts every 3 cycles; status write on timeout cycle leaves TO=1.
REQ-025 Period=0, CONT=1, START -> TO set every cycle; STOP|START write (0x000C) -> RUN=0.
REQ-026 Running with period=0x0001_0000, write snap at known cycle -> snap low/high read 0xFFF0/0x0000 when counter was 0x0000_FFF0; without macro reads 0.
REQ-027 Reset asserted 3 cycles into count -> next cycle RUN=0, TO=0, irq=0, counter=0xFFFF_FFFF.
